lc_arbiter: RTL and testbench

LC_ARBITER -- requirements
Module: lc_arbiter

---
 rtl/lc_arbiter.sv | 115 +++++++++++
 tb/tb_lc_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc_arbiter.sv
// lc_arbiter: arbitrates l1i/l1d line requests onto a single lower-cache port (LC_ARB_FIXED_PRIO_EN: l1d always wins)
module lc_arbiter #(
    parameter int ADDR_BITS = 64,
    parameter int LINE_BITS = 512
) (
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 cs_N_in,
    input  logic                 l1i_req_valid_in,
    output logic                 l1i_req_ready_out,
    input  logic [ADDR_BITS-1:0] l1i_req_addr_in,
    input  logic [LINE_BITS-1:0] l1i_req_value_in,
    input  logic                 l1i_req_we_in,
    output logic                 l1i_resp_valid_out,
    output logic [ADDR_BITS-1:0] l1i_resp_addr_out,
    output logic [LINE_BITS-1:0] l1i_resp_value_out,
    input  logic                 l1d_req_valid_in,
    output logic                 l1d_req_ready_out,
    input  logic [ADDR_BITS-1:0] l1d_req_addr_in,
    input  logic [LINE_BITS-1:0] l1d_req_value_in,
    input  logic                 l1d_req_we_in,
    output logic                 l1d_resp_valid_out,
    output logic [ADDR_BITS-1:0] l1d_resp_addr_out,
    output logic [LINE_BITS-1:0] l1d_resp_value_out,
    output logic                 lc_valid_out,
    input  logic                 lc_ready_in,
    output logic [ADDR_BITS-1:0] lc_addr_out,
    output logic [LINE_BITS-1:0] lc_value_out,
    output logic                 lc_we_out,
    input  logic                 lc_valid_in,
    input  logic [ADDR_BITS-1:0] lc_addr_in,
    input  logic [LINE_BITS-1:0] lc_value_in
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nx;
    logic grant_i, grant_d, fire, owner, favor_d, we_q, resp_fire;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0] value_q;

    assign lc_addr_out  = addr_q;
    assign lc_value_out = value_q;
    assign lc_we_out    = we_q;
    assign resp_fire    = state == WAIT && lc_valid_in;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk_in or negedge rst_N_in)
        if (!rst_N_in) state <= IDLE;
        else state <= state_nx;

    // Next state: one transaction outstanding, writebacks skip WAIT
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = fire ? ISSUE : IDLE;
            ISSUE:   state_nx = lc_ready_in ? (we_q ? IDLE : WAIT) : ISSUE;
            WAIT:    state_nx = lc_valid_in ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Grants are combinational in IDLE; reset masks them so ready is 0 at once
    always_comb begin
        grant_d = state == IDLE && !cs_N_in && rst_N_in && l1d_req_valid_in && (favor_d || !l1i_req_valid_in);
        grant_i = state == IDLE && !cs_N_in && rst_N_in && l1i_req_valid_in && !grant_d;
        fire = grant_i || grant_d;
        l1i_req_ready_out = grant_i;
        l1d_req_ready_out = grant_d;
        lc_valid_out = state == ISSUE;
    end

    // Capture the winner's payload and owner id at the grant handshake
    always_ff @(posedge clk_in or negedge rst_N_in)
        if (!rst_N_in) begin
            addr_q  <= '0;
            value_q <= '0;
            we_q    <= 1'b0;
            owner   <= 1'b0;
        end else if (fire) begin
            addr_q  <= grant_d ? l1d_req_addr_in : l1i_req_addr_in;
            value_q <= grant_d ? l1d_req_value_in : l1i_req_value_in;
            we_q    <= grant_d ? l1d_req_we_in : l1i_req_we_in;
            owner   <= grant_d;
        end

`ifdef LC_ARB_FIXED_PRIO_EN
    assign favor_d = 1'b1;
`else
    // Round-robin pointer: favour the requester that was not granted last
    always_ff @(posedge clk_in or negedge rst_N_in)
        if (!rst_N_in) favor_d <= 1'b0;
        else if (fire) favor_d <= grant_i;
`endif

    // One-cycle response pulse to the owner; data holds between responses
    always_ff @(posedge clk_in or negedge rst_N_in)
        if (!rst_N_in) begin
            l1i_resp_valid_out <= 1'b0;
            l1d_resp_valid_out <= 1'b0;
            l1i_resp_addr_out  <= '0;
            l1i_resp_value_out <= '0;
            l1d_resp_addr_out  <= '0;
            l1d_resp_value_out <= '0;
        end else begin
            l1i_resp_valid_out <= resp_fire && !owner;
            l1d_resp_valid_out <= resp_fire && owner;
            if (resp_fire && !owner) begin
                l1i_resp_addr_out  <= lc_addr_in;
                l1i_resp_value_out <= lc_value_in;
            end
            if (resp_fire && owner) begin
                l1d_resp_addr_out  <= lc_addr_in;
                l1d_resp_value_out <= lc_value_in;
            end
        end
endmodule

// File: tb/tb_lc_arbiter.sv
// tb_lc_arbiter: scoreboard bench for lc_arbiter grants, issue, responses and reset
module tb_lc_arbiter;
    localparam int AB = 64;
    localparam int LB = 512;

    logic clk_in = 1'b0;
    logic rst_N_in, cs_N_in;
    logic l1i_req_valid_in, l1i_req_ready_out, l1i_req_we_in, l1i_resp_valid_out;
    logic [AB-1:0] l1i_req_addr_in, l1i_resp_addr_out;
    logic [LB-1:0] l1i_req_value_in, l1i_resp_value_out;
    logic l1d_req_valid_in, l1d_req_ready_out, l1d_req_we_in, l1d_resp_valid_out;
    logic [AB-1:0] l1d_req_addr_in, l1d_resp_addr_out;
    logic [LB-1:0] l1d_req_value_in, l1d_resp_value_out;
    logic lc_valid_out, lc_ready_in, lc_we_out, lc_valid_in;
    logic [AB-1:0] lc_addr_out, lc_addr_in;
    logic [LB-1:0] lc_value_out, lc_value_in;

    typedef struct packed {
        logic          d;
        logic [AB-1:0] addr;
        logic [LB-1:0] value;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [AB-1:0] mon_addr;
    logic [LB-1:0] mon_val;
    int checks = 0;
    int errors = 0;

    lc_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB)) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in),
        .l1i_req_valid_in(l1i_req_valid_in), .l1i_req_ready_out(l1i_req_ready_out),
        .l1i_req_addr_in(l1i_req_addr_in), .l1i_req_value_in(l1i_req_value_in),
        .l1i_req_we_in(l1i_req_we_in), .l1i_resp_valid_out(l1i_resp_valid_out),
        .l1i_resp_addr_out(l1i_resp_addr_out), .l1i_resp_value_out(l1i_resp_value_out),
        .l1d_req_valid_in(l1d_req_valid_in), .l1d_req_ready_out(l1d_req_ready_out),
        .l1d_req_addr_in(l1d_req_addr_in), .l1d_req_value_in(l1d_req_value_in),
        .l1d_req_we_in(l1d_req_we_in), .l1d_resp_valid_out(l1d_resp_valid_out),
        .l1d_resp_addr_out(l1d_resp_addr_out), .l1d_resp_value_out(l1d_resp_value_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
        .lc_value_out(lc_value_out), .lc_we_out(lc_we_out), .lc_valid_in(lc_valid_in),
        .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in)
    );

    always #5 clk_in = ~clk_in;

    // Every response pulse must match the oldest expected response
    always @(negedge clk_in)
        if (l1i_resp_valid_out || l1d_resp_valid_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got l1i=%b l1d=%b, required no response", l1i_resp_valid_out, l1d_resp_valid_out);
            end else begin
                mon_e = q.pop_front();
                mon_addr = mon_e.d ? l1d_resp_addr_out : l1i_resp_addr_out;
                mon_val = mon_e.d ? l1d_resp_value_out : l1i_resp_value_out;
                if ({l1d_resp_valid_out, l1i_resp_valid_out} !== {mon_e.d, !mon_e.d} || mon_addr !== mon_e.addr || mon_val !== mon_e.value) begin
                    errors++;
                    $display("FAIL resp_match: got d/i valid=%b%b addr=%h value_ok=%b, required d/i valid=%b%b addr=%h",
                             l1d_resp_valid_out, l1i_resp_valid_out, mon_addr, mon_val === mon_e.value, mon_e.d, !mon_e.d, mon_e.addr);
                end
            end
        end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        rst_N_in = 1'b0; cs_N_in = 1'b0; lc_ready_in = 1'b0; lc_valid_in = 1'b0;
        lc_addr_in = '0; lc_value_in = '0;
        l1i_req_valid_in = 1'b1; l1i_req_addr_in = '0; l1i_req_value_in = '0; l1i_req_we_in = 1'b0;
        l1d_req_valid_in = 1'b1; l1d_req_addr_in = '0; l1d_req_value_in = '0; l1d_req_we_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({l1i_req_ready_out, l1d_req_ready_out, lc_valid_out, lc_we_out} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 0000", {l1i_req_ready_out, l1d_req_ready_out, lc_valid_out, lc_we_out});
        end
        checks++;
        if (lc_addr_out !== '0 || lc_value_out !== '0 || l1i_resp_addr_out !== '0 || l1d_resp_addr_out !== '0) begin
            errors++; $display("FAIL reset_data: got lc_addr=%h, required 0", lc_addr_out);
        end
        tick;
        rst_N_in = 1'b1; l1i_req_valid_in = 1'b0; l1d_req_valid_in = 1'b0;
    endtask

    task automatic test_read;
        logic [LB-1:0] v;
        v = {64{8'hAB}};
        l1i_req_valid_in = 1'b1; l1i_req_addr_in = 64'h1000; l1i_req_we_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({l1i_req_ready_out, l1d_req_ready_out} !== 2'b10) begin
            errors++; $display("FAIL read_grant: got i/d ready=%b%b, required 10", l1i_req_ready_out, l1d_req_ready_out);
        end
        tick;
        l1i_req_valid_in = 1'b0; lc_ready_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (lc_valid_out !== 1'b1 || lc_addr_out !== 64'h1000 || lc_we_out !== 1'b0 || l1i_req_ready_out !== 1'b0) begin
            errors++; $display("FAIL read_issue: got valid=%b addr=%h we=%b, required 1 1000 0", lc_valid_out, lc_addr_out, lc_we_out);
        end
        tick;
        lc_ready_in = 1'b0; lc_valid_in = 1'b1; lc_addr_in = 64'h1000; lc_value_in = v;
        q.push_back('{1'b0, 64'h1000, v});
        @(negedge clk_in);
        checks++;
        if (lc_valid_out !== 1'b0 || l1i_resp_valid_out !== 1'b0) begin
            errors++; $display("FAIL read_wait: got lc_valid=%b resp=%b, required 0 0", lc_valid_out, l1i_resp_valid_out);
        end
        tick;
        lc_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({l1i_resp_valid_out, l1d_resp_valid_out} !== 2'b10) begin
            errors++; $display("FAIL read_resp: got i/d resp=%b%b, required 10", l1i_resp_valid_out, l1d_resp_valid_out);
        end
        tick;
        @(negedge clk_in);
        checks++;
        if (l1i_resp_valid_out !== 1'b0 || l1i_resp_addr_out !== 64'h1000 || l1i_resp_value_out !== v) begin
            errors++; $display("FAIL read_hold: got valid=%b addr=%h, required 0 1000", l1i_resp_valid_out, l1i_resp_addr_out);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic exp_d;
        logic [AB-1:0] a;
        rst_N_in = 1'b0;
        tick;
        rst_N_in = 1'b1;
        l1i_req_valid_in = 1'b1; l1i_req_addr_in = 64'h100; l1i_req_we_in = 1'b0;
        l1d_req_valid_in = 1'b1; l1d_req_addr_in = 64'h200; l1d_req_we_in = 1'b0;
        lc_ready_in = 1'b1;
`ifdef LC_ARB_FIXED_PRIO_EN
        exp_d = 1'b1;
`else
        exp_d = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            a = exp_d ? 64'h200 : 64'h100;
            @(negedge clk_in);
            checks++;
            if ({l1d_req_ready_out, l1i_req_ready_out} !== {exp_d, !exp_d}) begin
                errors++; $display("FAIL rr_grant%0d: got d/i ready=%b%b, required %b%b", k, l1d_req_ready_out, l1i_req_ready_out, exp_d, !exp_d);
            end
            tick;
            @(negedge clk_in);
            checks++;
            if (lc_valid_out !== 1'b1 || lc_addr_out !== a) begin
                errors++; $display("FAIL rr_issue%0d: got valid=%b addr=%h, required 1 %h", k, lc_valid_out, lc_addr_out, a);
            end
            tick;
            tick;
            lc_valid_in = 1'b1; lc_addr_in = a; lc_value_in = {8{a ^ 64'h5A5A}};
            q.push_back('{exp_d, a, {8{a ^ 64'h5A5A}}});
            tick;
            lc_valid_in = 1'b0;
`ifndef LC_ARB_FIXED_PRIO_EN
            exp_d = !exp_d;
`endif
        end
        l1i_req_valid_in = 1'b0; l1d_req_valid_in = 1'b0; lc_ready_in = 1'b0;
        @(negedge clk_in);
        tick;
    endtask

    task automatic test_writeback;
        logic [LB-1:0] v;
        v = {8{64'hDEADBEEF00002040}};
        l1d_req_valid_in = 1'b1; l1d_req_addr_in = 64'h2040; l1d_req_value_in = v; l1d_req_we_in = 1'b1;
        lc_ready_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({l1d_req_ready_out, l1i_req_ready_out} !== 2'b10) begin
            errors++; $display("FAIL wb_grant: got d/i ready=%b%b, required 10", l1d_req_ready_out, l1i_req_ready_out);
        end
        tick;
        l1d_req_valid_in = 1'b0; l1d_req_we_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checks++;
            if (lc_valid_out !== 1'b1 || lc_addr_out !== 64'h2040 || lc_value_out !== v || lc_we_out !== 1'b1) begin
                errors++; $display("FAIL wb_stall%0d: got valid=%b addr=%h we=%b, required 1 2040 1", k, lc_valid_out, lc_addr_out, lc_we_out);
            end
            tick;
        end
        lc_ready_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (lc_valid_out !== 1'b1 || lc_addr_out !== 64'h2040) begin
            errors++; $display("FAIL wb_accept: got valid=%b addr=%h, required 1 2040", lc_valid_out, lc_addr_out);
        end
        tick;
        lc_ready_in = 1'b0; cs_N_in = 1'b1;
        l1i_req_valid_in = 1'b1; l1i_req_addr_in = 64'h3000; l1i_req_we_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (lc_valid_out !== 1'b0 || l1i_req_ready_out !== 1'b0) begin
            errors++; $display("FAIL cs_block: got lc_valid=%b ready=%b, required 0 0", lc_valid_out, l1i_req_ready_out);
        end
        tick;
        cs_N_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (l1i_req_ready_out !== 1'b1) begin
            errors++; $display("FAIL wb_idle: got ready=%b, required 1", l1i_req_ready_out);
        end
        tick;
        l1i_req_valid_in = 1'b0; lc_ready_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (lc_valid_out !== 1'b1 || lc_we_out !== 1'b1 || lc_addr_out !== 64'h3000) begin
            errors++; $display("FAIL wb2_issue: got valid=%b we=%b addr=%h, required 1 1 3000", lc_valid_out, lc_we_out, lc_addr_out);
        end
        tick;
        lc_ready_in = 1'b0; l1i_req_we_in = 1'b0;
        tick;
    endtask

    task automatic test_stray;
        logic [LB-1:0] v;
        v = {8{64'h0123456789ABCDEF}};
        lc_valid_in = 1'b1; lc_addr_in = 64'hBAD; lc_value_in = '1;
        tick;
        lc_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({l1i_resp_valid_out, l1d_resp_valid_out} !== 2'b00) begin
            errors++; $display("FAIL stray_idle: got i/d resp=%b%b, required 00", l1i_resp_valid_out, l1d_resp_valid_out);
        end
        tick;
        l1i_req_valid_in = 1'b1; l1i_req_addr_in = 64'h4000; l1i_req_we_in = 1'b0;
        tick;
        l1i_req_valid_in = 1'b0; lc_valid_in = 1'b1;
        tick;
        tick;
        lc_valid_in = 1'b0; lc_ready_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (lc_valid_out !== 1'b1 || {l1i_resp_valid_out, l1d_resp_valid_out} !== 2'b00) begin
            errors++; $display("FAIL stray_issue: got lc_valid=%b i/d resp=%b%b, required 1 00", lc_valid_out, l1i_resp_valid_out, l1d_resp_valid_out);
        end
        tick;
        lc_ready_in = 1'b0; lc_valid_in = 1'b1; lc_addr_in = 64'h4000; lc_value_in = v;
        q.push_back('{1'b0, 64'h4000, v});
        tick;
        lc_valid_in = 1'b0;
        @(negedge clk_in);
        tick;
    endtask

    task automatic test_reset_mid_wait;
        logic exp_d;
        l1i_req_valid_in = 1'b1; l1i_req_addr_in = 64'h5000; l1i_req_we_in = 1'b0;
        tick;
        l1i_req_valid_in = 1'b0; lc_ready_in = 1'b1;
        tick;
        lc_ready_in = 1'b0;
        tick;
        rst_N_in = 1'b0;
        #1;
        checks++;
        if ({l1i_req_ready_out, l1d_req_ready_out, lc_valid_out, l1i_resp_valid_out} !== 4'b0 || l1i_resp_addr_out !== '0 || lc_addr_out !== '0) begin
            errors++; $display("FAIL rst_async: got resp_addr=%h lc_addr=%h, required 0 0", l1i_resp_addr_out, lc_addr_out);
        end
        tick;
        rst_N_in = 1'b1; lc_valid_in = 1'b1; lc_addr_in = 64'h5000; lc_value_in = '1;
        tick;
        lc_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({l1i_resp_valid_out, l1d_resp_valid_out} !== 2'b00) begin
            errors++; $display("FAIL rst_ignore: got i/d resp=%b%b, required 00", l1i_resp_valid_out, l1d_resp_valid_out);
        end
        tick;
`ifdef LC_ARB_FIXED_PRIO_EN
        exp_d = 1'b1;
`else
        exp_d = 1'b0;
`endif
        l1i_req_valid_in = 1'b1; l1i_req_we_in = 1'b1;
        l1d_req_valid_in = 1'b1; l1d_req_we_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({l1d_req_ready_out, l1i_req_ready_out} !== {exp_d, !exp_d}) begin
            errors++; $display("FAIL rst_pointer: got d/i ready=%b%b, required %b%b", l1d_req_ready_out, l1i_req_ready_out, exp_d, !exp_d);
        end
        tick;
        l1i_req_valid_in = 1'b0; l1d_req_valid_in = 1'b0; lc_ready_in = 1'b1;
        tick;
        lc_ready_in = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_read;
        test_round_robin;
        test_writeback;
        test_stray;
        test_reset_mid_wait;
        repeat (2) tick;
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL resp_missing: got %0d responses outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
